// File: rtl/leitor_entradas.sv
// Front-panel button reader: debounces digit, coin, confirm and cancel keys
// and runs the vending state machine that feeds the 7-segment display driver.
module leitor_entradas #(
    parameter int DEB_CYCLES = 16,
    parameter int MAX_UNID   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn_digito,
    input  logic       btn_m25,
    input  logic       btn_m50,
    input  logic       btn_m100,
    input  logic       btn_confirma,
    input  logic       btn_cancela,
    output logic [1:0] estado,
    output logic [3:0] produto,
    output logic [3:0] valorMoedas,
    output logic       devolver,
    output logic       venda
);

    localparam int NB = 9;
    localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(DEB_CYCLES - 1);
    localparam logic [4:0]    MAX5    = 5'(MAX_UNID);

    localparam logic [2:0] S_ESPERA = 3'd0;
    localparam logic [2:0] S_DIG2   = 3'd1;
    localparam logic [2:0] S_PROD   = 3'd2;
    localparam logic [2:0] S_MOEDAS = 3'd3;

    logic [NB-1:0] w_raw;
    logic [NB-1:0] r_s1;
    logic [NB-1:0] r_s2;
    logic [NB-1:0] r_deb;
    logic [NB-1:0] r_deb_q;
    logic [CW-1:0] r_cnt [NB];
    logic [NB-1:0] w_ev;

    assign w_raw = {btn_cancela, btn_confirma, btn_m100,
                    btn_m50, btn_m25, btn_digito};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1    <= '0;
            r_s2    <= '0;
            r_deb   <= '0;
            r_deb_q <= '0;
            for (int i = 0; i < NB; i++) r_cnt[i] <= '0;
        end else begin
            r_s1    <= w_raw;
            r_s2    <= r_s1;
            r_deb_q <= r_deb;
            for (int i = 0; i < NB; i++) begin
                if (r_s2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_TOP) begin
                    r_deb[i] <= r_s2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_ev = r_deb & ~r_deb_q;

    // Only the highest-priority event of a cycle survives
    logic       w_cancel;
    logic       w_conf;
    logic       w_coin;
    logic       w_dig;
    logic [2:0] w_k;
    logic [1:0] w_dsel;

    assign w_cancel = w_ev[8];
    assign w_conf   = w_ev[7] & ~w_ev[8];
    assign w_coin   = |w_ev[6:4] & ~|w_ev[8:7];
    assign w_dig    = |w_ev[3:0] & ~|w_ev[8:4];

    always_comb begin
        w_k = 3'd0;
        priority case (1'b1)
            w_ev[6]: w_k = 3'd4;
            w_ev[5]: w_k = 3'd2;
            w_ev[4]: w_k = 3'd1;
            default: w_k = 3'd0;
        endcase
    end

    always_comb begin
        w_dsel = 2'd0;
        priority case (1'b1)
            w_ev[0]: w_dsel = 2'd0;
            w_ev[1]: w_dsel = 2'd1;
            w_ev[2]: w_dsel = 2'd2;
            w_ev[3]: w_dsel = 2'd3;
            default: w_dsel = 2'd0;
        endcase
    end

    function automatic logic [3:0] f_map(input logic [1:0] a, input logic [1:0] b);
        case ({a, b})
            4'b0000, 4'b0100, 4'b0101,
            4'b1000, 4'b1001, 4'b1010,
            4'b1011, 4'b1100, 4'b1101: f_map = {a, b};
            default:                   f_map = 4'hF;
        endcase
    endfunction

    logic [2:0] r_state;
    logic [2:0] w_nxt;
    logic [1:0] r_d1;
    logic [1:0] r_estado;
    logic [3:0] r_produto;
    logic [3:0] r_valor;
    logic       r_dev;
    logic       r_venda;

    logic [1:0] w_d1_n;
    logic [1:0] w_estado_n;
    logic [3:0] w_produto_n;
    logic [3:0] w_valor_n;
    logic       w_dev_n;
    logic       w_venda_n;
    logic [4:0] w_sum;
    logic       w_sale;

    assign w_sum  = {1'b0, r_valor} + {2'b00, w_k};
    assign w_sale = w_conf & ~r_dev & (r_valor != 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_ESPERA;
            r_d1      <= '0;
            r_estado  <= '0;
            r_produto <= '0;
            r_valor   <= '0;
            r_dev     <= 1'b0;
            r_venda   <= 1'b0;
        end else begin
            r_state   <= w_nxt;
            r_d1      <= w_d1_n;
            r_estado  <= w_estado_n;
            r_produto <= w_produto_n;
            r_valor   <= w_valor_n;
            r_dev     <= w_dev_n;
            r_venda   <= w_venda_n;
        end
    end

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_ESPERA: if (w_dig) w_nxt = S_DIG2;
            S_DIG2: begin
                if (w_cancel)   w_nxt = S_ESPERA;
                else if (w_dig) w_nxt = S_PROD;
            end
            S_PROD: begin
                if (w_cancel)    w_nxt = S_ESPERA;
                else if (w_conf) w_nxt = (r_produto != 4'hF) ? S_MOEDAS : S_ESPERA;
            end
            S_MOEDAS: if (w_cancel || w_sale) w_nxt = S_ESPERA;
            default: w_nxt = S_ESPERA;
        endcase
    end

    always_comb begin
        w_d1_n      = r_d1;
        w_produto_n = r_produto;
        w_valor_n   = r_valor;
        w_dev_n     = r_dev;
        w_venda_n   = 1'b0;
        case (r_state)
            S_ESPERA: if (w_dig) w_d1_n = w_dsel;
            S_DIG2: begin
                if (w_cancel)   w_produto_n = 4'h0;
                else if (w_dig) w_produto_n = f_map(r_d1, w_dsel);
            end
            S_PROD: begin
                if (w_cancel) begin
                    w_produto_n = 4'h0;
                end else if (w_conf && r_produto != 4'hF) begin
                    w_valor_n = 4'd0;
                    w_dev_n   = 1'b0;
                end
            end
            S_MOEDAS: begin
                if (w_cancel) begin
                    w_valor_n   = 4'd0;
                    w_dev_n     = 1'b0;
                    w_produto_n = 4'h0;
                end else if (w_sale) begin
                    w_venda_n   = 1'b1;
                    w_valor_n   = 4'd0;
                    w_produto_n = 4'h0;
                end else if (w_coin && !r_dev) begin
                    if (w_sum <= MAX5) w_valor_n = w_sum[3:0];
                    else               w_dev_n   = 1'b1;
                end
            end
            default: begin
                w_d1_n      = 2'd0;
                w_produto_n = 4'h0;
                w_valor_n   = 4'd0;
                w_dev_n     = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_estado_n = 2'b00;
        case (w_nxt)
            S_DIG2, S_PROD: w_estado_n = 2'b01;
            S_MOEDAS:       w_estado_n = 2'b10;
            default:        w_estado_n = 2'b00;
        endcase
    end

    assign estado      = r_estado;
    assign produto     = r_produto;
    assign valorMoedas = r_valor;
    assign devolver    = r_dev;
    assign venda       = r_venda;

endmodule
